// File: rtl/obi_arb_pkg.sv
// Helpers shared by the OBI data-port arbiter and its ID FIFO.
package obi_arb_pkg;

    // A single requester still needs a 1-bit ID so the FIFO has something to store.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned MaxNumReq = 8;

    typedef logic [id_width(MaxNumReq)-1:0] arb_id_t;

endpackage

// File: rtl/obi_pkg.sv
// OBI data channel request/response types shared by cores, arbiters and the bus.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered OBI transactions.
module obi_arb_id_fifo #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Depth need not fill the pointer range, so wrap explicitly.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + 1'b1;
        if (do_pop)  rd_d = (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/obi_data_if_arbiter.sv
// Round-robin arbiter sharing one OBI data master port among NumReq requesters,
// with in-order routing of responses back to the issuing requester.
module obi_data_if_arbiter
    import obi_pkg::*;
    import obi_arb_pkg::*;
#(
    parameter int unsigned NumReq         = 3,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  obi_req_t  [NumReq-1:0] req_req_i,
    output obi_resp_t [NumReq-1:0] req_resp_o,
    output obi_req_t               mst_req_o,
    input  obi_resp_t              mst_resp_i,
    output logic                   idle_o,
    output logic                   rvalid_err_o
);

    localparam int unsigned IdW = id_width(NumReq);

    logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0] locked_id_q, locked_id_d;
    logic           lock_q, lock_d;
    logic           err_q, err_d;
    logic [IdW-1:0] winner, cand, head;
    logic           found, fwd, hs, pop, full, empty;

    // Winner defaults to rr_ptr so the forwarded fields stay deterministic when idle.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        cand   = '0;
        if (lock_q) begin
            winner = locked_id_q;
            found  = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NumReq; k++) begin
                cand = IdW'((rr_ptr_q + k) % NumReq);
                if (!found && req_req_i[cand].req) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    // Full is registered state, so a same-cycle rvalid never reopens forwarding.
    assign fwd = found & req_req_i[winner].req & ~full & ~rst_i;
    assign hs  = fwd & mst_resp_i.gnt;
    assign pop = mst_resp_i.rvalid & ~empty & ~rst_i;

    always_comb begin
        mst_req_o     = req_req_i[winner];
        mst_req_o.req = fwd;
    end

    always_comb begin
        req_resp_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            req_resp_o[i].gnt    = hs  && (winner == IdW'(i));
            req_resp_o[i].rvalid = pop && (head == IdW'(i));
            req_resp_o[i].rdata  = mst_resp_i.rdata;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        err_d       = err_q | (mst_resp_i.rvalid & empty);
        if (hs) begin
            lock_d   = 1'b0;
            rr_ptr_d = (winner == IdW'(NumReq - 1)) ? '0 : winner + 1'b1;
        end else if (fwd) begin
            lock_d      = 1'b1;
            locked_id_d = winner;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            lock_q      <= 1'b0;
            locked_id_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
            err_q       <= err_d;
        end
    end

    obi_arb_id_fifo #(
        .Width (IdW),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (hs),
        .data_i  (winner),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    assign idle_o       = empty & ~lock_q;
    assign rvalid_err_o = err_q;

endmodule

// File: tb/tb_obi_data_if_arbiter.sv
// Directed test-plan steps plus an OBI-compliant random phase, checked against a queue model.
module tb_obi_data_if_arbiter;
    import obi_pkg::*;
    import obi_arb_pkg::*;

    localparam int N  = 3;
    localparam int MO = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    obi_req_t  [N-1:0]    req_req;
    obi_resp_t [N-1:0]    req_resp;
    obi_req_t             mst_req;
    obi_resp_t            mst_resp;
    logic                 idle, rerr;

    always #5 clk = ~clk;

    obi_data_if_arbiter #(.NumReq(N), .MaxOutstanding(MO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_req_i    (req_req),
        .req_resp_o   (req_resp),
        .mst_req_o    (mst_req),
        .mst_resp_i   (mst_resp),
        .idle_o       (idle),
        .rvalid_err_o (rerr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: ID queue, round-robin pointer, lock, sticky error.
    int   idq[$];
    int   rr;
    bit   lk;
    int   lk_id;
    bit   m_err;

    logic [31:0]  addr_v [N];
    logic [N-1:0] o_gnt, o_rv, e_gnt;
    logic [31:0]  o_addr, o_rdata;
    logic         o_req, o_idle, o_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input logic [N-1:0] rq, input bit g, input bit rv,
                       input logic [31:0] rd);
        int w;
        int pre;
        bit e_req;
        logic [N-1:0] e_rv;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < N; i++) begin
            req_req[i].req   = rq[i];
            req_req[i].we    = addr_v[i][4];
            req_req[i].be    = 4'hF;
            req_req[i].addr  = addr_v[i];
            req_req[i].wdata = ~addr_v[i];
        end
        mst_resp.gnt    = g;
        mst_resp.rvalid = rv;
        mst_resp.rdata  = rd;
        #1;
        w = -1;
        if (lk) w = lk_id;
        else
            for (int k = 0; k < N; k++)
                if (w < 0 && rq[(rr + k) % N]) w = (rr + k) % N;
        e_req = !r && (w >= 0) && rq[w] && (idq.size() < MO);
        e_gnt = '0;
        if (e_req && g) e_gnt[w] = 1'b1;
        e_rv = '0;
        if (!r && rv && idq.size() > 0) e_rv[idq[0]] = 1'b1;
        for (int i = 0; i < N; i++) begin
            o_gnt[i] = req_resp[i].gnt;
            o_rv[i]  = req_resp[i].rvalid;
        end
        o_req   = mst_req.req;
        o_addr  = mst_req.addr;
        o_rdata = req_resp[0].rdata;
        o_idle  = idle;
        o_err   = rerr;
        chk("mst_req", o_req, e_req);
        if (w >= 0) chk("mst_addr", o_addr, addr_v[w]);
        chk("gnt_vec", o_gnt, e_gnt);
        chk("rvalid_vec", o_rv, e_rv);
        chk("rdata_bcast", req_resp[N-1].rdata, rd);
        chk("idle", o_idle, (idq.size() == 0) && !lk);
        chk("rvalid_err", o_err, m_err);
        @(posedge clk);
        if (r) begin
            idq.delete();
            rr = 0; lk = 0; m_err = 0;
        end else begin
            pre = idq.size();
            if (rv) begin
                if (pre > 0) void'(idq.pop_front());
                else m_err = 1;
            end
            if (e_req && g) begin
                idq.push_back(w);
                rr = (w + 1) % N;
                lk = 0;
            end else if (e_req) begin
                lk = 1;
                lk_id = w;
            end
        end
    endtask

    task automatic rstc();
        cyc(1'b1, '0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int gcnt;
        int order[$];
        int dst[$];
        logic [31:0] dq[$];
        logic [N-1:0] pend;
        bit g, rv, r;

        rst = 1'b1;
        req_req = '0;
        mst_resp = '0;
        for (int i = 0; i < N; i++) addr_v[i] = 32'h1000 * (i + 1);
        repeat (2) @(posedge clk);
        rr = 0; lk = 0; m_err = 0; lk_id = 0;

        // Reset state
        rstc();
        cyc(1'b0, '0, 1'b0, 1'b0, 32'h0);
        chk("reset_idle", o_idle, 1'b1);
        chk("reset_err", o_err, 1'b0);

        // Single requester, four reads, rvalid one cycle later
        rstc();
        gcnt = 0;
        for (int t = 0; t < 5; t++) begin
            cyc(1'b0, (t < 4) ? 3'b001 : 3'b000, 1'b1, t >= 1, 32'hA0 + t - 1);
            gcnt += int'(o_gnt[0]);
            if (o_rv[0]) dq.push_back(o_rdata);
            chk("s1_other_rv", o_rv[2:1], 2'b00);
        end
        chk("s1_gnt_count", gcnt, 4);
        chk("s1_rv_count", dq.size(), 4);
        for (int k = 0; k < 4; k++) chk("s1_rdata", (k < dq.size()) ? dq[k] : 32'hX, 32'hA0 + k);

        // All requesters hold req; rvalid two cycles after gnt
        rstc();
        for (int t = 0; t < 8; t++) begin
            cyc(1'b0, (t < 6) ? 3'b111 : 3'b000, 1'b1, t >= 2, 32'hB0 + t - 2);
            for (int i = 0; i < N; i++) if (o_gnt[i]) order.push_back(i);
            for (int i = 0; i < N; i++) if (o_rv[i]) dst.push_back(i);
        end
        chk("s2_ngrants", order.size(), 6);
        chk("s2_nrv", dst.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk("s2_order", (k < order.size()) ? order[k] : -1, k % 3);
            chk("s2_route", (k < dst.size()) ? dst[k] : -1, k % 3);
        end
        cyc(1'b0, '0, 1'b0, 1'b0, 32'h0);
        chk("s2_idle_end", o_idle, 1'b1);

        // Held request stays selected until granted
        rstc();
        addr_v[0] = 32'h200;
        addr_v[1] = 32'h100;
        cyc(1'b0, 3'b010, 1'b0, 1'b0, 32'h0);
        chk("s3_addr_c0", o_addr, 32'h100);
        cyc(1'b0, 3'b011, 1'b0, 1'b0, 32'h0);
        chk("s3_addr_c1", o_addr, 32'h100);
        cyc(1'b0, 3'b011, 1'b0, 1'b0, 32'h0);
        chk("s3_addr_c2", o_addr, 32'h100);
        cyc(1'b0, 3'b011, 1'b1, 1'b0, 32'h0);
        chk("s3_addr_gnt", o_addr, 32'h100);
        chk("s3_gnt1", o_gnt, 3'b010);
        cyc(1'b0, 3'b001, 1'b1, 1'b0, 32'h0);
        chk("s3_gnt0_next", o_gnt, 3'b001);

        // FIFO full blocks forwarding; a pop frees a slot only for the next cycle
        rstc();
        gcnt = 0;
        for (int t = 0; t < 6; t++) begin
            cyc(1'b0, 3'b100, 1'b1, 1'b0, 32'h0);
            gcnt += int'(o_gnt[2]);
        end
        chk("s4_grants", gcnt, 4);
        chk("s4_blocked", o_req, 1'b0);
        cyc(1'b0, 3'b100, 1'b1, 1'b1, 32'h55);
        chk("s4_pop_same_req", o_req, 1'b0);
        chk("s4_pop_same_gnt", o_gnt, 3'b000);
        chk("s4_pop_rv", o_rv, 3'b100);
        cyc(1'b0, 3'b100, 1'b1, 1'b0, 32'h0);
        chk("s4_pop_next_gnt", o_gnt, 3'b100);

        // Stray rvalid with nothing outstanding
        rstc();
        cyc(1'b0, '0, 1'b0, 1'b1, 32'h77);
        chk("s5_no_rv", o_rv, 3'b000);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, 32'h0);
        chk("s5_err_sticky", o_err, 1'b1);
        rstc();
        cyc(1'b0, '0, 1'b0, 1'b0, 32'h0);
        chk("s5_err_cleared", o_err, 1'b0);

        // Reset with two outstanding, then a late rvalid
        addr_v[0] = 32'h1000;
        addr_v[1] = 32'h2000;
        cyc(1'b0, 3'b001, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 3'b010, 1'b1, 1'b0, 32'h0);
        chk("s6_busy", o_idle, 1'b0);
        rstc();
        cyc(1'b0, '0, 1'b0, 1'b0, 32'h0);
        chk("s6_idle", o_idle, 1'b1);
        chk("s6_req", o_req, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 32'h99);
        chk("s6_late_no_rv", o_rv, 3'b000);
        cyc(1'b0, '0, 1'b0, 1'b0, 32'h0);
        chk("s6_late_err", o_err, 1'b1);

        // Random OBI-compliant traffic: req held with fixed fields until granted
        rstc();
        pend = '0;
        for (int it = 0; it < 800; it++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]   = 1'b1;
                    addr_v[i] = $urandom;
                end
            g  = ($urandom_range(0, 3) != 0);
            rv = (idq.size() > 0) && ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 99) == 0);
            cyc(r, pend, g, rv, $urandom);
            pend = pend & ~e_gnt;
            if (r) pend = '0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
